// File: rtl/tdc_hw_stats_if.sv
// Sample/result bundle between the TDC pop-count stage, tdc_hw_stats and its consumer.
// TDC_HW_STATS_SUMSQ_EN adds the res_sumsq result lane.
interface tdc_hw_stats_if #(
    parameter int HW_W       = 7,
    parameter int LOG2_NSAMP = 4
);
    logic                       start;
    logic                       sample_en;
    logic [HW_W-1:0]            hw_in;
    logic                       busy;
    logic                       res_valid;
    logic                       res_ready;
    logic [HW_W+LOG2_NSAMP-1:0] res_sum;
    logic [HW_W-1:0]            res_mean;
    logic [HW_W-1:0]            res_min;
    logic [HW_W-1:0]            res_max;
    logic                       start_drop;
`ifdef TDC_HW_STATS_SUMSQ_EN
    logic [2*HW_W+LOG2_NSAMP-1:0] res_sumsq;

    modport master (
        output start, sample_en, hw_in, res_ready,
        input  busy, res_valid, res_sum, res_mean, res_min, res_max, start_drop, res_sumsq
    );
    modport slave (
        input  start, sample_en, hw_in, res_ready,
        output busy, res_valid, res_sum, res_mean, res_min, res_max, start_drop, res_sumsq
    );
`else
    modport master (
        output start, sample_en, hw_in, res_ready,
        input  busy, res_valid, res_sum, res_mean, res_min, res_max, start_drop
    );
    modport slave (
        input  start, sample_en, hw_in, res_ready,
        output busy, res_valid, res_sum, res_mean, res_min, res_max, start_drop
    );
`endif
endinterface

// File: rtl/tdc_hw_stats.sv
// Windowed sum/mean/min/max of TDC Hamming weights with a flush-skip phase and valid/ready result.
// Optional TDC_HW_STATS_SUMSQ_EN also accumulates the sum of squares for variance.
module tdc_hw_stats #(
    parameter int HW_W       = 7,
    parameter int LOG2_NSAMP = 4,
    parameter int SKIP       = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          en,
    tdc_hw_stats_if.slave bus
);
    localparam int SW  = HW_W + LOG2_NSAMP;
    localparam int SKW = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic [SKW-1:0]        SKIP_LAST = SKW'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [LOG2_NSAMP-1:0] SAMP_LAST = '1;

    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_ACCUM, S_HOLD} state_t;
    localparam state_t FIRST = (SKIP == 0) ? S_ACCUM : S_SKIP;

    state_t                state, nxt;
    logic [SKW-1:0]        skip_cnt;
    logic [LOG2_NSAMP-1:0] samp_cnt;
    logic [SW-1:0]         acc, sum_nxt, res_sum;
    logic [HW_W-1:0]       run_min, run_max, min_nxt, max_nxt, res_min, res_max;
    logic                  start_ok, skip_done, win_done, start_drop;
    logic                  busy, res_valid;

    function automatic logic [HW_W-1:0] mean_of(input logic [SW-1:0] s);
        return s[SW-1 -: HW_W];
    endfunction

    // A start is only honoured when no window or unread result is pending.
    assign start_ok  = bus.start && (state == S_IDLE || (state == S_HOLD && bus.res_ready));
    assign skip_done = (state == S_SKIP) && bus.sample_en && (skip_cnt == SKIP_LAST);
    assign win_done  = (state == S_ACCUM) && bus.sample_en && (samp_cnt == SAMP_LAST);
    assign sum_nxt   = acc + SW'(bus.hw_in);
    assign min_nxt   = (bus.hw_in < run_min) ? bus.hw_in : run_min;
    assign max_nxt   = (bus.hw_in > run_max) ? bus.hw_in : run_max;

`ifdef TDC_HW_STATS_SUMSQ_EN
    localparam int QW = 2*HW_W + LOG2_NSAMP;
    logic [2*HW_W-1:0] sq;
    logic [QW-1:0]     acc_sq, sq_nxt, res_sumsq;
    assign sq            = (2*HW_W)'(bus.hw_in) * (2*HW_W)'(bus.hw_in);
    assign sq_nxt        = acc_sq + QW'(sq);
    assign bus.res_sumsq = res_sumsq;
`endif

    always_ff @(posedge clk) begin
        if (!rst)
            state <= S_IDLE;
        else if (en)
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (start_ok)      nxt = FIRST;
            S_SKIP:  if (skip_done)     nxt = S_ACCUM;
            S_ACCUM: if (win_done)      nxt = S_HOLD;
            S_HOLD:  if (bus.res_ready) nxt = bus.start ? FIRST : S_IDLE;
            default:                    nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        res_valid = 1'b0;
        case (state)
            S_SKIP, S_ACCUM: busy      = 1'b1;
            S_HOLD:          res_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            skip_cnt   <= '0;
            samp_cnt   <= '0;
            acc        <= '0;
            run_min    <= '0;
            run_max    <= '0;
            res_sum    <= '0;
            res_min    <= '0;
            res_max    <= '0;
            start_drop <= 1'b0;
`ifdef TDC_HW_STATS_SUMSQ_EN
            acc_sq     <= '0;
            res_sumsq  <= '0;
`endif
        end else if (en) begin
            if (start_ok) begin
                skip_cnt   <= '0;
                samp_cnt   <= '0;
                acc        <= '0;
                run_min    <= '1;
                run_max    <= '0;
                start_drop <= 1'b0;
`ifdef TDC_HW_STATS_SUMSQ_EN
                acc_sq     <= '0;
`endif
            end else begin
                if (bus.start && state != S_IDLE)
                    start_drop <= 1'b1;
                if (state == S_SKIP && bus.sample_en)
                    skip_cnt <= skip_cnt + 1'b1;
                if (state == S_ACCUM && bus.sample_en) begin
                    acc      <= sum_nxt;
                    run_min  <= min_nxt;
                    run_max  <= max_nxt;
                    samp_cnt <= samp_cnt + 1'b1;
`ifdef TDC_HW_STATS_SUMSQ_EN
                    acc_sq   <= sq_nxt;
                    if (win_done) res_sumsq <= sq_nxt;
`endif
                    if (win_done) begin
                        res_sum <= sum_nxt;
                        res_min <= min_nxt;
                        res_max <= max_nxt;
                    end
                end
            end
        end
    end

    assign bus.busy       = busy;
    assign bus.res_valid  = res_valid;
    assign bus.res_sum    = res_sum;
    assign bus.res_mean   = mean_of(res_sum);
    assign bus.res_min    = res_min;
    assign bus.res_max    = res_max;
    assign bus.start_drop = start_drop;
endmodule
